idft_sample_buf: RTL and testbench

- Dual-bank sample buffer sitting directly upstream/downstream of the IDFT core.
- Accepts DEPTH complex input samples from a valid/ready host stream and holds them in the input RAM.
- Asserts start and serves the core's read requests (ri_*, addr, data_ok), then captures the core's write-backs (wi_*) into the result RAM.
- Streams the results out on a valid/ready interface and re-arms for the next frame.

---
 rtl/idft_sample_buf_if.sv | 44 ++++
 rtl/idft_sample_buf.sv | 172 +++++++++++++++++
 tb/tb_idft_sample_buf.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/idft_sample_buf_if.sv
// Bundle of host stream, IDFT core and result stream signals for idft_sample_buf.
// master = environment (host, core, sink); slave = the buffer.
interface idft_sample_buf_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;
  logic              start;
  logic              core_done;
  logic              ri_real;
  logic              ri_imag;
  logic [ADDR_W-1:0] core_addr;
  logic              data_ok;
  logic [DATA_W-1:0] x_real_out;
  logic [DATA_W-1:0] x_imag_out;
  logic              wi_real;
  logic              wi_imag;
  logic [DATA_W-1:0] X_real_in;
  logic [DATA_W-1:0] X_imag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_real;
  logic [DATA_W-1:0] out_imag;
  logic              out_last;
  logic              busy;
  logic              err;

  modport master (
    output in_valid, in_real, in_imag, core_done, ri_real, ri_imag, core_addr,
           wi_real, wi_imag, X_real_in, X_imag_in, out_ready,
    input  in_ready, start, data_ok, x_real_out, x_imag_out, out_valid,
           out_real, out_imag, out_last, busy, err
  );

  modport slave (
    input  in_valid, in_real, in_imag, core_done, ri_real, ri_imag, core_addr,
           wi_real, wi_imag, X_real_in, X_imag_in, out_ready,
    output in_ready, start, data_ok, x_real_out, x_imag_out, out_valid,
           out_real, out_imag, out_last, busy, err
  );
endinterface

// File: rtl/idft_sample_buf.sv
// Dual-bank sample buffer around the IDFT core: LOAD host samples, RUN serves core reads/writes, DRAIN streams results.
// Define IDFT_BUF_ERR_EN to enable the sticky protocol error flag (err tied 0 otherwise).
module idft_sample_buf #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  idft_sample_buf_if.slave bus
);
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

  // Counter preload so data_ok lands exactly READ_LAT cycles after the accepted request.
  localparam logic [1:0] LAT_INIT = (READ_LAT >= 2) ? 2'(READ_LAT - 2) : 2'd0;
  localparam bit         LAT_ONE  = (READ_LAT == 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_in_re  [DEPTH];
  logic [DATA_W-1:0] r_in_im  [DEPTH];
  logic [DATA_W-1:0] r_res_re [DEPTH];
  logic [DATA_W-1:0] r_res_im [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, r_rd_addr;
  logic              r_arm, r_rd_pend, r_data_ok;
  logic [1:0]        r_lat_cnt;
  logic [DATA_W-1:0] r_x_re, r_x_im, r_out_re, r_out_im;

  logic              w_run, w_ri, w_in_acc, w_out_acc, w_rd_acc, w_fire, w_last_in, w_last_out;
  logic              w_in_ready, w_out_valid, w_busy;
  logic [ADDR_W-1:0] w_fire_addr, w_rd_nxt;
  logic [DATA_W-1:0] w_res0_re, w_res0_im;

  assign w_run       = (r_state == S_RUN);
  assign w_ri        = bus.ri_real | bus.ri_imag;
  assign w_in_acc    = bus.in_valid & w_in_ready;
  assign w_out_acc   = w_out_valid & bus.out_ready;
  assign w_rd_acc    = w_run & w_ri & ~r_rd_pend;
  assign w_fire      = w_run & ~bus.core_done &
                       (LAT_ONE ? w_rd_acc : (r_rd_pend && r_lat_cnt == 2'd0));
  assign w_fire_addr = LAT_ONE ? bus.core_addr : r_rd_addr;
  assign w_last_in   = w_in_acc && (r_wr_ptr == LAST_ADDR);
  assign w_last_out  = w_out_acc && (r_rd_ptr == LAST_ADDR);
  assign w_rd_nxt    = r_rd_ptr + 1'b1;
  // Forward a write-back to entry 0 landing on the same cycle as core_done.
  assign w_res0_re   = (bus.wi_real && bus.core_addr == '0) ? bus.X_real_in : r_res_re[0];
  assign w_res0_im   = (bus.wi_imag && bus.core_addr == '0) ? bus.X_imag_in : r_res_im[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_in_ready = r_arm;
        if (w_last_in) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (bus.core_done) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (w_last_out) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm     <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_addr <= '0;
      r_rd_pend <= 1'b0;
      r_lat_cnt <= 2'd0;
      r_data_ok <= 1'b0;
      r_x_re    <= '0;
      r_x_im    <= '0;
      r_out_re  <= '0;
      r_out_im  <= '0;
    end else begin
      r_arm     <= 1'b1;
      r_data_ok <= w_fire;
      if (w_in_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fire) begin
        r_x_re <= r_in_re[w_fire_addr];
        r_x_im <= r_in_im[w_fire_addr];
      end
      if (!w_run || bus.core_done) begin
        r_rd_pend <= 1'b0;
      end else if (w_rd_acc && !LAT_ONE) begin
        r_rd_pend <= 1'b1;
        r_lat_cnt <= LAT_INIT;
        r_rd_addr <= bus.core_addr;
      end else if (r_rd_pend) begin
        if (r_lat_cnt == 2'd0) r_rd_pend <= 1'b0;
        else                   r_lat_cnt <= r_lat_cnt - 2'd1;
      end
      if (w_run && bus.core_done) begin
        r_out_re <= w_res0_re;
        r_out_im <= w_res0_im;
      end else if (w_out_acc) begin
        r_rd_ptr <= w_rd_nxt;
        r_out_re <= r_res_re[w_rd_nxt];
        r_out_im <= r_res_im[w_rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_acc) begin
      r_in_re[r_wr_ptr] <= bus.in_real;
      r_in_im[r_wr_ptr] <= bus.in_imag;
    end
    if (w_run && bus.wi_real) r_res_re[bus.core_addr] <= bus.X_real_in;
    if (w_run && bus.wi_imag) r_res_im[bus.core_addr] <= bus.X_imag_in;
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.start      = w_run;
  assign bus.busy       = w_busy;
  assign bus.data_ok    = r_data_ok;
  assign bus.x_real_out = r_x_re;
  assign bus.x_imag_out = r_x_im;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_real   = r_out_re;
  assign bus.out_imag   = r_out_im;
  assign bus.out_last   = w_out_valid && (r_rd_ptr == LAST_ADDR);

`ifdef IDFT_BUF_ERR_EN
  logic [DEPTH-1:0] r_mask_re, r_mask_im, w_mask_re, w_mask_im, w_onehot;
  logic             r_err, w_err_set;

  assign w_onehot  = DEPTH'(1) << bus.core_addr;
  assign w_mask_re = r_mask_re | (bus.wi_real ? w_onehot : '0);
  assign w_mask_im = r_mask_im | (bus.wi_imag ? w_onehot : '0);
  assign w_err_set = (w_run & w_ri & r_rd_pend) |
                     (~w_run & (bus.wi_real | bus.wi_imag | bus.core_done)) |
                     (w_run & bus.core_done & ~((&w_mask_re) & (&w_mask_im)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask_re <= '0;
      r_mask_im <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_last_in) begin
        r_mask_re <= '0;
        r_mask_im <= '0;
      end else if (w_run) begin
        r_mask_re <= w_mask_re;
        r_mask_im <= w_mask_im;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_idft_sample_buf.sv
// Directed bench for idft_sample_buf (READ_LAT=3): frames, latency, backpressure, mid-run reset, err flag.
module tb_idft_sample_buf;
  typedef struct packed {
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic [31:0] exp_re;
    logic [31:0] exp_im;
  } vec_t;

`ifdef IDFT_BUF_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [2][8];

  always #5 clk = ~clk;

  idft_sample_buf_if #(.ADDR_W(3), .DATA_W(32)) bus ();

  idft_sample_buf #(.DEPTH(8), .ADDR_W(3), .DATA_W(32), .READ_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    mk = '{32'(a), 32'(b), 32'(c), 32'(d)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(input int s);
    int g;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_real  = tbl[s][k].in_re;
      bus.in_imag  = tbl[s][k].in_im;
      g = 0;
      while (!bus.in_ready && g < 20) begin @(negedge clk); g++; end
      if (g >= 20) chk("load_timeout", 32'(g), 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("in_ready_run", 32'(bus.in_ready), 32'd0);
    chk("start_run", 32'(bus.start), 32'd1);
  endtask

  // Behavioural core: read entry i, then write back x>>>1 for the first n_wr entries.
  task automatic run_core(input int s, input int n_rd, input int n_wr);
    int g;
    logic [31:0] xr, xi;
    for (int i = 0; i < n_rd; i++) begin
      bus.core_addr = 3'(i);
      bus.ri_real = 1'b1;
      bus.ri_imag = 1'b1;
      @(negedge clk);
      bus.ri_real = 1'b0;
      bus.ri_imag = 1'b0;
      g = 1;
      while (!bus.data_ok && g < 20) begin @(negedge clk); g++; end
      chk("read_lat", 32'(g), 32'd3);
      chk("x_real", bus.x_real_out, tbl[s][i].in_re);
      chk("x_imag", bus.x_imag_out, tbl[s][i].in_im);
      xr = bus.x_real_out;
      xi = bus.x_imag_out;
      if (i < n_wr) begin
        bus.wi_real   = 1'b1;
        bus.wi_imag   = 1'b1;
        bus.X_real_in = 32'($signed(xr) >>> 1);
        bus.X_imag_in = 32'($signed(xi) >>> 1);
        @(negedge clk);
        bus.wi_real = 1'b0;
        bus.wi_imag = 1'b0;
      end
    end
  endtask

  task automatic done();
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("start_drain", 32'(bus.start), 32'd0);
    chk("busy_drain", 32'(bus.busy), 32'd1);
    chk("out_valid_drain", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain(input int s, input bit toggle, input bit hold_in);
    int idx = 0;
    int cyc = 0;
    if (hold_in) begin
      bus.in_valid = 1'b1;
      bus.in_real  = 32'hDEAD;
      bus.in_imag  = 32'hBEEF;
    end
    while (idx < 8 && cyc < 100) begin
      bus.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (hold_in && cyc == 0) chk("in_ready_held", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        chk("out_real", bus.out_real, tbl[s][idx].exp_re);
        chk("out_imag", bus.out_imag, tbl[s][idx].exp_im);
        chk("out_last", 32'(bus.out_last), 32'(idx == 7));
        idx++;
        if (idx == 8) bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (idx < 8) chk("drain_timeout", 32'(idx), 32'd8);
    if (toggle) chk("drain_cycles", 32'(cyc), 32'd15);
    bus.out_ready = 1'b0;
    chk("out_valid_end", 32'(bus.out_valid), 32'd0);
    chk("busy_end", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    tbl[0][0] = mk(0, 0, 0, 0);        tbl[1][0] = mk(0, 7, 0, 3);
    tbl[0][1] = mk(16, -1, 8, -1);     tbl[1][1] = mk(-10, 9, -5, 4);
    tbl[0][2] = mk(32, -2, 16, -1);    tbl[1][2] = mk(-20, 11, -10, 5);
    tbl[0][3] = mk(48, -3, 24, -2);    tbl[1][3] = mk(-30, 13, -15, 6);
    tbl[0][4] = mk(64, -4, 32, -2);    tbl[1][4] = mk(-40, 15, -20, 7);
    tbl[0][5] = mk(80, -5, 40, -3);    tbl[1][5] = mk(-50, 17, -25, 8);
    tbl[0][6] = mk(96, -6, 48, -3);    tbl[1][6] = mk(-60, 19, -30, 9);
    tbl[0][7] = mk(112, -7, 56, -4);   tbl[1][7] = mk(-70, 21, -35, 10);

    bus.in_valid = 0; bus.in_real = 0; bus.in_imag = 0; bus.core_done = 0;
    bus.ri_real = 0; bus.ri_imag = 0; bus.core_addr = 0; bus.wi_real = 0;
    bus.wi_imag = 0; bus.X_real_in = 0; bus.X_imag_in = 0; bus.out_ready = 0;

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_data_ok", 32'(bus.data_ok), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_x_real", bus.x_real_out, 32'd0);
    chk("rst_out_real", bus.out_real, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Frame A: nominal, host keeps in_valid high through DRAIN.
    load(0); run_core(0, 8, 8); done(); drain(0, 1'b0, 1'b1);
    chk("err_clean", 32'(bus.err), 32'd0);

    // Frame B back-to-back with different data, out_ready toggling.
    load(1); run_core(1, 8, 8); done(); drain(1, 1'b1, 1'b0);

    // Frame C aborted by reset after three write-backs.
    load(0); run_core(0, 3, 3);
    rst = 1'b1;
    #1;
    chk("midrst_start", 32'(bus.start), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);

    // Frame D after the abort must be clean.
    load(0); run_core(0, 8, 8); done(); drain(0, 1'b0, 1'b0);

    // Frame E: only six write-backs before core_done.
    load(0); run_core(0, 8, 6); done();
    chk("err_set", 32'(bus.err), 32'(EXP_ERR));
    drain(0, 1'b0, 1'b0);
    chk("err_held", 32'(bus.err), 32'(EXP_ERR));

    // Frame F: exact READ_LAT timing, overlapping request ignored.
    load(1);
    bus.core_addr = 3'd5; bus.ri_real = 1'b1;
    @(negedge clk);
    chk("lat_t1", 32'(bus.data_ok), 32'd0);
    bus.core_addr = 3'd2;
    @(negedge clk);
    chk("lat_t2", 32'(bus.data_ok), 32'd0);
    bus.ri_real = 1'b0;
    @(negedge clk);
    chk("lat_t3", 32'(bus.data_ok), 32'd1);
    chk("lat_x_real", bus.x_real_out, tbl[1][5].in_re);
    chk("lat_x_imag", bus.x_imag_out, tbl[1][5].in_im);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat_no_extra", 32'(bus.data_ok), 32'd0);
    end
    chk("lat_x_hold", bus.x_real_out, tbl[1][5].in_re);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
